// File: rtl/parity_uart_tx_pkg.sv
// Shared types and constants for the parity UART transmitter.
// Provides the FSM state encoding, parity mode constants, the 9-bit
// parity-encoded word payload and a parity consistency helper.
package parity_uart_tx_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned WORD_W    = DATA_W + 1;
  localparam int unsigned BIT_IDX_W = 3;

  // Parity mode select values
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Parity-encoded word: [8] parity, [7:0] data
  typedef struct packed {
    logic              par;
    logic [DATA_W-1:0] data;
  } par_word_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // True when the parity bit disagrees with the selected mode
  function automatic logic parity_bad(input par_word_t w, input logic mode);
    return w.par != ((^w.data) ^ (mode == PAR_ODD));
  endfunction

endpackage

// File: rtl/parity_uart_tx_if.sv
// Upstream word handshake between the parity generator and the transmitter.
//   data_even / data_odd : parity-encoded words from the generator
//   parity_sel           : 0 picks data_even, 1 picks data_odd
//   in_valid / in_ready  : accept when both are high
interface parity_uart_tx_if;
  import parity_uart_tx_pkg::*;

  par_word_t data_even;
  par_word_t data_odd;
  logic      parity_sel;
  logic      in_valid;
  logic      in_ready;

  modport master (
    output data_even, data_odd, parity_sel, in_valid,
    input  in_ready
  );

  modport slave (
    input  data_even, data_odd, parity_sel, in_valid,
    output in_ready
  );

endinterface

// File: rtl/parity_uart_baud_gen.sv
// Baud counter for the parity UART transmitter.
//   clk, rst_n  : clock, async active-low reset
//   en, clr     : count enable, synchronous clear (clr wins)
//   bit_tick_c  : high in the last cycle of a bit (counter wrap cycle)
//   pre_tick_c  : high in the cycle before the wrap cycle
module parity_uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic bit_tick_c,
  output logic pre_tick_c
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count with wrap at CLKS_PER_BIT-1
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bit_tick_c = en && !clr && (cnt_q == CNT_MAX);
  assign pre_tick_c = en && !clr && (cnt_q == CNT_PRE);

endmodule

// File: rtl/parity_uart_tx.sv
// Parity UART transmitter: accepts one parity-encoded word per handshake and
// sends start, 8 data bits LSB first, parity, STOP_BITS stop bits on txd.
//   clk, rst_n : clock, async active-low reset
//   bus        : word handshake (slave side); in_ready decoded from state
//   txd        : serial line, idles high
//   busy       : frame in progress
//   done       : one-cycle pulse in the last stop-bit cycle
//   par_err    : one-cycle pulse after accepting a word with wrong parity
module parity_uart_tx
  import parity_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  parity_uart_tx_if.slave        bus,
  output logic                   txd,
  output logic                   busy,
  output logic                   done,
  output logic                   par_err
);

  state_e                 state_q, state_d;
  logic [WORD_W-1:0]      shift_q, shift_d;
  logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic                   stop_q, stop_d;
  logic                   txd_q, txd_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   par_err_q, par_err_d;

  logic                   bit_tick_c;
  logic                   pre_tick_c;
  logic                   accept_c;
  logic                   stop_last_c;
  par_word_t              sel_word_c;

  assign bus.in_ready = (state_q == ST_IDLE);
  assign accept_c     = bus.in_valid && (state_q == ST_IDLE);
  assign sel_word_c   = bus.parity_sel ? bus.data_odd : bus.data_even;
  assign stop_last_c  = (STOP_BITS == 1) ? 1'b1 : stop_q;

  parity_uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (state_q != ST_IDLE),
    .clr        (state_q == ST_IDLE),
    .bit_tick_c (bit_tick_c),
    .pre_tick_c (pre_tick_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept_c)                     state_d = ST_START;
      ST_START:  if (bit_tick_c)                   state_d = ST_DATA;
      ST_DATA:   if (bit_tick_c && (bit_idx_q == BIT_IDX_W'(7)))
                                                   state_d = ST_PARITY;
      ST_PARITY: if (bit_tick_c)                   state_d = ST_STOP;
      ST_STOP:   if (bit_tick_c && stop_last_c)    state_d = ST_IDLE;
      default:                                     state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    stop_d    = stop_q;
    txd_d     = txd_q;
    busy_d    = (state_d != ST_IDLE);
    done_d    = 1'b0;
    par_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          shift_d   = sel_word_c;
          bit_idx_d = '0;
          stop_d    = 1'b0;
          txd_d     = 1'b0;
          par_err_d = parity_bad(sel_word_c, bus.parity_sel);
        end
      end
      ST_START: begin
        if (bit_tick_c) txd_d = shift_q[0];
      end
      ST_DATA: begin
        // Shift as each data bit ends; after the 8th, shift_q[1] is the parity bit
        if (bit_tick_c) begin
          shift_d   = shift_q >> 1;
          txd_d     = shift_q[1];
          bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
        end
      end
      ST_PARITY: begin
        if (bit_tick_c) txd_d = 1'b1;
      end
      ST_STOP: begin
        // Registered done must be set one cycle early to land in the last cycle
        if (pre_tick_c && stop_last_c) done_d = 1'b1;
        if (bit_tick_c && !stop_last_c) stop_d = 1'b1;
      end
      default: begin
        txd_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      bit_idx_q <= '0;
      stop_q    <= 1'b0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      stop_q    <= stop_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      par_err_q <= par_err_d;
    end
  end

  assign txd     = txd_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign par_err = par_err_q;

endmodule

// File: tb/tb_parity_uart_tx.sv
// Directed testbench for parity_uart_tx with CLKS_PER_BIT=4.
// dut1 uses one stop bit, dut2 uses two stop bits.
module tb_parity_uart_tx;

  localparam int unsigned CPB = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  parity_uart_tx_if bus1 ();
  parity_uart_tx_if bus2 ();

  logic txd1, busy1, done1, perr1;
  logic txd2, busy2, done2, perr2;

  parity_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
    .txd(txd1), .busy(busy1), .done(done1), .par_err(perr1)
  );

  parity_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave),
    .txd(txd2), .busy(busy2), .done(done2), .par_err(perr2)
  );

  int errors = 0;
  int checks = 0;
  int dut_sel = 1;

  logic m_txd, m_busy, m_done, m_perr, m_rdy;
  logic txd_log  [0:127];
  logic busy_log [0:127];
  logic done_log [0:127];
  logic perr_log [0:127];
  logic rdy_log  [0:127];

  always_comb begin
    if (dut_sel == 2) begin
      m_txd = txd2; m_busy = busy2; m_done = done2; m_perr = perr2; m_rdy = bus2.in_ready;
    end else begin
      m_txd = txd1; m_busy = busy1; m_done = done1; m_perr = perr1; m_rdy = bus1.in_ready;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Log one sample per cycle at the falling edge
  task automatic record(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      txd_log[start+i]  = m_txd;
      busy_log[start+i] = m_busy;
      done_log[start+i] = m_done;
      perr_log[start+i] = m_perr;
      rdy_log[start+i]  = m_rdy;
    end
  endtask

  // Present a word with valid high; returns 1 ns after the accepting edge
  task automatic offer(input int d, input logic [8:0] ev, input logic [8:0] od, input logic ps);
    @(negedge clk);
    dut_sel = d;
    if (d == 2) begin
      bus2.data_even = ev; bus2.data_odd = od; bus2.parity_sel = ps; bus2.in_valid = 1'b1;
    end else begin
      bus1.data_even = ev; bus1.data_odd = od; bus1.parity_sel = ps; bus1.in_valid = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // Bit-centre samples of an 11-bit frame starting at log index start
  function automatic logic [10:0] bits11(input int start);
    logic [10:0] v;
    for (int k = 0; k < 11; k++) v[k] = txd_log[start + 4*k + 2];
    return v;
  endfunction

  function automatic int count_done(input int start, input int n);
    int c = 0;
    for (int i = start; i < start + n; i++) if (done_log[i]) c++;
    return c;
  endfunction

  function automatic int count_perr(input int start, input int n);
    int c = 0;
    for (int i = start; i < start + n; i++) if (perr_log[i]) c++;
    return c;
  endfunction

  function automatic int count_idle(input int start, input int n);
    int c = 0;
    for (int i = start; i < start + n; i++) if (!busy_log[i] && txd_log[i]) c++;
    return c;
  endfunction

  function automatic int count_high(input int start, input int n);
    int c = 0;
    for (int i = start; i < start + n; i++) if (txd_log[i]) c++;
    return c;
  endfunction

  initial begin
    rst_n = 1'b0;
    bus1.data_even = '0; bus1.data_odd = '0; bus1.parity_sel = 1'b0; bus1.in_valid = 1'b0;
    bus2.data_even = '0; bus2.data_odd = '0; bus2.parity_sel = 1'b0; bus2.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_txd",   32'(txd1), 32'd1);
    check_eq("rst_ready", 32'(bus1.in_ready), 32'd1);
    check_eq("rst_busy",  32'(busy1), 32'd0);
    check_eq("rst_done",  32'(done1), 32'd0);
    check_eq("rst_perr",  32'(perr1), 32'd0);

    // Even frame 9'h101
    offer(1, 9'h101, 9'h000, 1'b0);
    bus1.in_valid = 1'b0;
    record(0, 60);
    check_eq("even_bits",   32'(bits11(0)), 32'(11'b11000000010));
    check_eq("even_start",  32'(txd_log[0]), 32'd0);
    check_eq("even_busy0",  32'(busy_log[0]), 32'd1);
    check_eq("even_rdy0",   32'(rdy_log[0]), 32'd0);
    check_eq("even_busy43", 32'(busy_log[43]), 32'd1);
    check_eq("even_busy44", 32'(busy_log[44]), 32'd0);
    check_eq("even_rdy44",  32'(rdy_log[44]), 32'd1);
    check_eq("even_done43", 32'(done_log[43]), 32'd1);
    check_eq("even_ndone",  32'(count_done(0, 60)), 32'd1);
    check_eq("even_nperr",  32'(count_perr(0, 60)), 32'd0);

    // Odd frame 9'h100 (data 0x00, parity 1)
    offer(1, 9'h000, 9'h100, 1'b1);
    bus1.in_valid = 1'b0;
    record(0, 60);
    check_eq("odd_bits",  32'(bits11(0)), 32'(11'b11000000000));
    check_eq("odd_nperr", 32'(count_perr(0, 60)), 32'd0);
    check_eq("odd_ndone", 32'(count_done(0, 60)), 32'd1);

    // Corrupt parity: even mode, data 0x01 with parity 0
    offer(1, 9'h001, 9'h000, 1'b0);
    bus1.in_valid = 1'b0;
    record(0, 60);
    check_eq("bad_perr0", 32'(perr_log[0]), 32'd1);
    check_eq("bad_nperr", 32'(count_perr(0, 60)), 32'd1);
    check_eq("bad_bits",  32'(bits11(0)), 32'(11'b10000000010));
    check_eq("bad_done",  32'(done_log[43]), 32'd1);
    check_eq("bad_ndone", 32'(count_done(0, 60)), 32'd1);

    // Two stop bits on dut2, word 9'h0A5
    offer(2, 9'h0A5, 9'h000, 1'b0);
    bus2.in_valid = 1'b0;
    record(0, 60);
    check_eq("stop2_bits",   32'(bits11(0)), 32'(11'b10101001010));
    check_eq("stop2_busy47", 32'(busy_log[47]), 32'd1);
    check_eq("stop2_busy48", 32'(busy_log[48]), 32'd0);
    check_eq("stop2_high",   32'(count_high(40, 8)), 32'd8);
    check_eq("stop2_done47", 32'(done_log[47]), 32'd1);
    check_eq("stop2_ndone",  32'(count_done(0, 60)), 32'd1);
    check_eq("stop2_nperr",  32'(count_perr(0, 60)), 32'd0);

    // Back-to-back on dut1: second word presented while the first is in flight
    offer(1, 9'h101, 9'h000, 1'b0);
    bus1.data_even = 9'h0A5;
    record(0, 60);
    bus1.in_valid = 1'b0;
    record(60, 40);
    check_eq("b2b_bits_a",  32'(bits11(0)), 32'(11'b11000000010));
    check_eq("b2b_done_a",  32'(done_log[43]), 32'd1);
    check_eq("b2b_gap_busy", 32'(busy_log[44]), 32'd0);
    check_eq("b2b_gap_txd", 32'(txd_log[44]), 32'd1);
    check_eq("b2b_start_b", 32'(txd_log[45]), 32'd0);
    check_eq("b2b_busy_b",  32'(busy_log[45]), 32'd1);
    check_eq("b2b_idle",    32'(count_idle(0, 89)), 32'd1);
    check_eq("b2b_bits_b",  32'(bits11(45)), 32'(11'b10101001010));
    check_eq("b2b_done_b",  32'(done_log[88]), 32'd1);
    check_eq("b2b_end",     32'(busy_log[89]), 32'd0);
    check_eq("b2b_ndone",   32'(count_done(0, 100)), 32'd2);

    // Reset in the middle of data bit 3
    offer(1, 9'h101, 9'h000, 1'b0);
    bus1.in_valid = 1'b0;
    record(0, 18);
    check_eq("mid_txd_pre", 32'(txd1), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_txd",   32'(txd1), 32'd1);
    check_eq("mid_busy",  32'(busy1), 32'd0);
    check_eq("mid_ready", 32'(bus1.in_ready), 32'd1);
    record(0, 3);
    check_eq("mid_ndone_rst", 32'(count_done(0, 3)), 32'd0);
    rst_n = 1'b1;
    record(0, 4);
    check_eq("mid_ndone_rel", 32'(count_done(0, 4)), 32'd0);
    check_eq("mid_busy_rel",  32'(busy_log[3]), 32'd0);
    check_eq("mid_rdy_rel",   32'(rdy_log[3]), 32'd1);
    offer(1, 9'h000, 9'h100, 1'b1);
    bus1.in_valid = 1'b0;
    record(0, 60);
    check_eq("post_bits",  32'(bits11(0)), 32'(11'b11000000000));
    check_eq("post_done",  32'(done_log[43]), 32'd1);
    check_eq("post_ndone", 32'(count_done(0, 60)), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
